// File: rtl/mbist_march_seq_pkg.sv
// Shared March C- types, element table and op helpers for the MBIST sequencer.
package mbist_pkg;

    typedef enum logic [1:0] {W0, W1, R0, R1} op_t;
    typedef enum logic {UP, DOWN} dir_t;
    typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_t;

    localparam int NUM_ELEMS = 6;

    typedef struct packed {
        dir_t       dir;
        logic [1:0] nops;
        op_t        op0;
        op_t        op1;
    } elem_desc_t;

    // Up/down-either elements (E0, E5) are walked upwards.
    localparam elem_desc_t MARCH_TABLE [NUM_ELEMS] = '{
        '{dir: UP,   nops: 2'd1, op0: W0, op1: W0},
        '{dir: UP,   nops: 2'd2, op0: R0, op1: W1},
        '{dir: UP,   nops: 2'd2, op0: R1, op1: W0},
        '{dir: DOWN, nops: 2'd2, op0: R0, op1: W1},
        '{dir: DOWN, nops: 2'd2, op0: R1, op1: W0},
        '{dir: UP,   nops: 2'd1, op0: R0, op1: R0}
    };

    function automatic elem_desc_t march_elem(input elem_t e);
        case (e)
            E0:      return MARCH_TABLE[0];
            E1:      return MARCH_TABLE[1];
            E2:      return MARCH_TABLE[2];
            E3:      return MARCH_TABLE[3];
            E4:      return MARCH_TABLE[4];
            E5:      return MARCH_TABLE[5];
            default: return MARCH_TABLE[0];
        endcase
    endfunction

    function automatic elem_t next_elem(input elem_t e);
        case (e)
            E0:      return E1;
            E1:      return E2;
            E2:      return E3;
            E3:      return E4;
            E4:      return E5;
            default: return E0;
        endcase
    endfunction

    function automatic logic op_bg(input op_t op);
        return (op == W1) || (op == R1);
    endfunction

    function automatic logic op_is_write(input op_t op);
        return (op == W0) || (op == W1);
    endfunction

endpackage

// File: rtl/mbist_march_seq_if.sv
// Controller/memory-side bundle of the March sequencer; master = sequencer.
interface mbist_march_seq_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              ld;
    logic              NbarT;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we;
    logic              re;
    logic [2:0]        elem;
    logic              cout;

    modport master (
        input  ld, NbarT,
        output addr, data, we, re, elem, cout
    );

    modport slave (
        output ld, NbarT,
        input  addr, data, we, re, elem, cout
    );
endinterface

// File: rtl/mbist_march_seq_addr_counter.sv
// Loadable up/down address counter with a terminal-count flag for the current direction.
module mbist_addr_counter
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              en,
    input  dir_t              dir,
    output logic [ADDR_W-1:0] q,
    output logic              term
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= (dir == UP) ? q + 1'b1 : q - 1'b1;
        end
    end

    assign term = (dir == UP) ? (q == '1) : (q == '0);

endmodule

// File: rtl/mbist_march_seq.sv
// March C- sequencer: one memory op per NbarT cycle, cout on the last read of E5.
// Optional build macro MBIST_CHECKERBOARD_EN selects a 0x55/0xAA per-address data background.
//
// state (elem) | meaning
// E0           | up,   w0
// E1           | up,   r0 then w1
// E2           | up,   r1 then w0
// E3           | down, r0 then w1
// E4           | down, r1 then w0
// E5           | up,   r0; terminal op raises cout and wraps to E0/addr 0
module mbist_march_seq
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    mbist_march_seq_if.master   bus
);

    elem_t             elem;
    logic              opi;
    elem_desc_t        desc;
    op_t               cur_op;
    logic              last_op;
    logic              issue;
    logic              step;
    logic              wrap;
    logic              term;
    logic              cnt_load;
    logic [ADDR_W-1:0] cnt_load_val;
    logic [ADDR_W-1:0] addr;
    elem_t             elem_nx;
    logic              bg;
    logic [DATA_W-1:0] data_pat;

    assign desc    = march_elem(elem);
    assign cur_op  = opi ? desc.op1 : desc.op0;
    assign last_op = opi | (desc.nops == 2'd1);
    assign elem_nx = next_elem(elem);

    // rst gates issue so the strobes drop the instant reset rises, not at the next edge.
    assign issue = bus.NbarT & ~bus.ld & ~rst;
    assign step  = issue & last_op;
    assign wrap  = step & term;

    // Wrapping from E5 lands on E0, which is an up element, so this also self-cleans to 0.
    assign cnt_load     = bus.ld | wrap;
    assign cnt_load_val = (bus.ld || march_elem(elem_nx).dir == UP) ? '0 : '1;

    mbist_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (step),
        .dir      (desc.dir),
        .q        (addr),
        .term     (term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem <= E0;
            opi  <= 1'b0;
        end else if (bus.ld) begin
            elem <= E0;
            opi  <= 1'b0;
        end else if (issue) begin
            if (last_op) begin
                opi <= 1'b0;
                if (term) begin
                    elem <= elem_nx;
                end
            end else begin
                opi <= 1'b1;
            end
        end
    end

    assign bg = op_bg(cur_op);

`ifdef MBIST_CHECKERBOARD_EN
    if (DATA_W % 2 != 0) begin : g_bad_data_w
        $error("mbist_march_seq: checkerboard background needs an even DATA_W");
    end
    assign data_pat = {DATA_W{bg ^ addr[0]}} ^ {(DATA_W/2){2'b01}};
`else
    assign data_pat = {DATA_W{bg}};
`endif

    assign bus.addr = addr;
    assign bus.elem = elem;
    assign bus.we   = issue & op_is_write(cur_op);
    assign bus.re   = issue & ~op_is_write(cur_op);
    assign bus.data = issue ? data_pat : '0;
    assign bus.cout = wrap & (elem == E5);

endmodule
